// File: rtl/bram_stream_reader.sv
// Read sequencer for a 2-cycle-latency BRAM port (OUTREG mode). Streams len bytes
// from base upward, with read issue throttled by buffer credits so nothing is lost.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 12,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic                  bram_ce_o,
  output logic                  bram_oce_o,
  input  logic [DATA_WIDTH-1:0] bram_do_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic [1:0]            dbg_state_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  p1_q, p2_q;
  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_nxt, credit_used;
  logic                  issue, push, pop;

  // Stream handshake: a byte transfers in any cycle where m_valid_o & m_ready_i;
  // m_valid_o never drops and m_data_o never changes until that byte is taken.
  assign push        = p2_q;
  assign pop         = (count_q != '0) && m_ready_i;
  assign count_nxt   = count_q + CNT_W'(push) - CNT_W'(pop);
  // Slots already promised (stored + in flight) must leave room for one more read.
  assign credit_used = count_q + CNT_W'(p1_q) + CNT_W'(p2_q);
  assign issue       = (state_q == ISSUE) && (credit_used < DEPTH_C) && !abort_i;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) state_d = ISSUE;
          else             done_d  = 1'b1;
        end
      end
      ISSUE: begin
        if (issue && (rem_q == LEN_WIDTH'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (!p1_q && !p2_q && (count_nxt == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if ((state_q == IDLE) && start_i && !abort_i) begin
        addr_q <= base_addr_i;
        rem_q  <= len_i;
      end else if (issue) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        rem_q  <= rem_q - LEN_WIDTH'(1);
      end
      p1_q <= issue;
      p2_q <= p1_q && !abort_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (abort_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= bram_do_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_nxt;
    end
  end

  assign bram_addr_o = addr_q;
  assign bram_ce_o   = issue;
  assign bram_oce_o  = p1_q;
  assign m_valid_o   = (count_q != '0);
  assign m_data_o    = buf_q[rd_ptr_q];
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural OUTREG-mode BRAM on port A.
module tb_bram_stream_reader;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int LW = 12;

  logic          clk, rst_n;
  logic          start_i, abort_i, m_ready_i;
  logic [AW-1:0] base_addr_i;
  logic [LW-1:0] len_i;
  logic          busy_o, done_o, bram_ce_o, bram_oce_o, m_valid_o;
  logic [AW-1:0] bram_addr_o;
  logic [DW-1:0] bram_do_i, m_data_o;
  logic [1:0]    dbg_state_o;

  int checks = 0;
  int failures = 0;
  int ce_cnt = 0;
  int done_cnt = 0;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];

  bram_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .bram_addr_o(bram_addr_o), .bram_ce_o(bram_ce_o), .bram_oce_o(bram_oce_o),
    .bram_do_i(bram_do_i), .m_valid_o(m_valid_o), .m_data_o(m_data_o),
    .m_ready_i(m_ready_i), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory contents: addr[7:0] ^ {addr[10:8],5'b0} ^ 8'h3C
  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return a[7:0] ^ {a[10:8], 5'b00000} ^ 8'h3C;
  endfunction

  logic [DW-1:0] mem [2048];
  logic [AW-1:0] ra;
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = mem_val(AW'(i));
    bram_do_i = '0;
    ra = '0;
  end
  always @(posedge clk) begin
    if (bram_ce_o) ra <= bram_addr_o;
    if (bram_oce_o) bram_do_i <= mem[ra];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor: handshakes, issue and done counts, hold-while-stalled check
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      chk("hold_valid", m_valid_o, 1'b1);
      chk("hold_data", m_data_o, prev_data);
    end
    prev_stall = rst_n && m_valid_o && !m_ready_i && !abort_i;
    prev_data  = m_data_o;
    if (m_valid_o && m_ready_i) got_q.push_back(m_data_o);
    if (bram_ce_o) ce_cnt++;
    if (done_o) done_cnt++;
    if (start_i) assert (len_i <= LW'(2048)) else $error("illegal len_i %0d", len_i);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start(input logic [AW-1:0] base, input logic [LW-1:0] len);
    start_i = 1'b1;
    base_addr_i = base;
    len_i = len;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_o && n < 200) begin
      tick();
      n++;
    end
    chk(tag, done_o, 1'b1);
    tick();
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk({tag, "_byte"}, got_q[i], exp_q[i]);
    end
  endtask

  logic [7:0]    t1_data [4] = '{8'h2C, 8'h2D, 8'h2E, 8'h2F};
  logic [AW-1:0] t2_addr [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
  logic [7:0]    t2_data [4] = '{8'h22, 8'h23, 8'h3C, 8'h3D};

  initial begin
    int ce0, dn0;
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; m_ready_i = 1'b1;
    base_addr_i = '0; len_i = '0;
    ticks(2);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_ce", bram_ce_o, 1'b0);
    chk("rst_oce", bram_oce_o, 1'b0);
    chk("rst_addr", bram_addr_o, 11'h000);
    chk("rst_valid", m_valid_o, 1'b0);
    chk("rst_data", m_data_o, 8'h00);
    chk("rst_state", dbg_state_o, 2'd0);
    rst_n = 1'b1;
    ticks(2);

    // T1: base 0x010 len 4, exact cycle timing
    got_q.delete();
    start(11'h010, 12'd4);
    for (int c = 1; c <= 8; c++) begin
      chk("t1_ce", bram_ce_o, (c <= 4));
      if (c <= 4) chk("t1_addr", bram_addr_o, 11'h010 + 11'(c - 1));
      chk("t1_oce", bram_oce_o, (c >= 2 && c <= 5));
      chk("t1_valid", m_valid_o, (c >= 4 && c <= 7));
      if (c >= 4 && c <= 7) chk("t1_data", m_data_o, t1_data[c-4]);
      chk("t1_done", done_o, (c == 8));
      chk("t1_busy", busy_o, (c < 8));
      if (c == 1) chk("t1_state", dbg_state_o, 2'd1);
      tick();
    end
    chk("t1_done_pulse", done_o, 1'b0);

    // T2: wrap at 0x7FF
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(t2_data[i]);
    start(11'h7FE, 12'd4);
    for (int c = 1; c <= 4; c++) begin
      chk("t2_ce", bram_ce_o, 1'b1);
      chk("t2_addr", bram_addr_o, t2_addr[c-1]);
      tick();
    end
    wait_done("t2_done");
    check_stream("t2");

    // T3: backpressure from cycle 3 to 15
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(mem_val(11'h020 + 11'(i)));
    ce0 = ce_cnt;
    start(11'h020, 12'd16);
    tick();
    tick();
    m_ready_i = 1'b0;
    ticks(12);
    chk("t3_stall_issues", ce_cnt - ce0, 4);
    chk("t3_stall_valid", m_valid_o, 1'b1);
    chk("t3_stall_ce", bram_ce_o, 1'b0);
    chk("t3_stall_popped", got_q.size(), 0);
    tick();
    m_ready_i = 1'b1;
    wait_done("t3_done");
    check_stream("t3");
    chk("t3_total_issues", ce_cnt - ce0, 16);

    // T4: zero length
    ce0 = ce_cnt;
    start(11'h555, 12'd0);
    chk("t4_done", done_o, 1'b1);
    chk("t4_busy", busy_o, 1'b0);
    chk("t4_ce", bram_ce_o, 1'b0);
    tick();
    chk("t4_done_pulse", done_o, 1'b0);
    chk("t4_busy2", busy_o, 1'b0);
    chk("t4_no_issue", ce_cnt - ce0, 0);

    // T5: abort at cycle 10 (with an ignored start), then a fresh transfer
    start(11'h200, 12'd32);
    ticks(9);
    abort_i = 1'b1;
    start_i = 1'b1;
    base_addr_i = 11'h300;
    len_i = 12'd5;
    dn0 = done_cnt;
    tick();
    abort_i = 1'b0;
    start_i = 1'b0;
    chk("t5_ce", bram_ce_o, 1'b0);
    chk("t5_valid", m_valid_o, 1'b0);
    chk("t5_busy", busy_o, 1'b0);
    chk("t5_done", done_o, 1'b0);
    ticks(5);
    chk("t5_no_done", done_cnt - dn0, 0);
    chk("t5_flushed", m_valid_o, 1'b0);
    chk("t5_idle", busy_o, 1'b0);
    got_q.delete();
    exp_q.delete();
    exp_q.push_back(8'h1C);
    exp_q.push_back(8'h1D);
    start(11'h100, 12'd2);
    wait_done("t5_restart_done");
    check_stream("t5");

    // T6: start while busy is ignored
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(mem_val(11'h040 + 11'(i)));
    dn0 = done_cnt;
    start(11'h040, 12'd6);
    tick();
    start_i = 1'b1;
    base_addr_i = 11'h300;
    len_i = 12'd3;
    tick();
    start_i = 1'b0;
    chk("t6_addr", bram_addr_o, 11'h042);
    wait_done("t6_done");
    ticks(4);
    check_stream("t6");
    chk("t6_one_done", done_cnt - dn0, 1);
    chk("t6_idle", busy_o, 1'b0);

    // T7: abort wins over start while idle
    ce0 = ce_cnt;
    abort_i = 1'b1;
    start(11'h050, 12'd4);
    abort_i = 1'b0;
    chk("t7_busy", busy_o, 1'b0);
    chk("t7_ce", bram_ce_o, 1'b0);
    ticks(3);
    chk("t7_no_issue", ce_cnt - ce0, 0);

    // T8: reset mid-transfer
    dn0 = done_cnt;
    start(11'h060, 12'd8);
    ticks(3);
    rst_n = 1'b0;
    #1;
    chk("t8_busy", busy_o, 1'b0);
    chk("t8_ce", bram_ce_o, 1'b0);
    chk("t8_oce", bram_oce_o, 1'b0);
    chk("t8_valid", m_valid_o, 1'b0);
    chk("t8_addr", bram_addr_o, 11'h000);
    tick();
    rst_n = 1'b1;
    ticks(6);
    chk("t8_no_done", done_cnt - dn0, 0);
    chk("t8_quiet", m_valid_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
